// File: rtl/obi_dma_copy_engine.sv
// Single-channel word-copy DMA engine: reads len words from a source pointer and
// writes them to a destination pointer over OBI, one transaction outstanding.
module obi_dma_copy_engine #(
    parameter int unsigned  AddrWidth   = 32,
    parameter int unsigned  DataWidth   = 32,
    parameter int unsigned  LenWidth    = 16,
    parameter int unsigned  NumSbrPorts = 4,
    parameter int unsigned  SelLsb      = 12,
    localparam int unsigned SelWidth    = (NumSbrPorts > 1) ? $clog2(NumSbrPorts) : 1,
    localparam int unsigned BeWidth     = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] src_addr_i,
    input  logic [AddrWidth-1:0] dst_addr_i,
    input  logic [LenWidth-1:0]  len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 dma_active_o,
    output logic [SelWidth-1:0]  dma_select_o,
    output logic                 obi_req_o,
    output logic [AddrWidth-1:0] obi_addr_o,
    output logic                 obi_we_o,
    output logic [BeWidth-1:0]   obi_be_o,
    output logic [DataWidth-1:0] obi_wdata_o,
    input  logic                 obi_gnt_i,
    input  logic                 obi_rvalid_i,
    input  logic [DataWidth-1:0] obi_rdata_i,
    input  logic                 obi_err_i
);

    localparam logic [AddrWidth-1:0] WordInc   = AddrWidth'(BeWidth);
    localparam logic [AddrWidth-1:0] AlignMask = ~(WordInc - AddrWidth'(1));

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_WAIT = 3'd4;

    logic [2:0]           state_q;
    logic                 done_q;
    logic                 err_q;
    logic [AddrWidth-1:0] src_q;
    logic [AddrWidth-1:0] dst_q;
    logic [LenWidth-1:0]  cnt_q;
    logic [DataWidth-1:0] data_q;
    logic                 rd_phase;
    logic                 wr_phase;
    logic                 accept;

    assign rd_phase = (state_q == RD_REQ) || (state_q == RD_WAIT);
    assign wr_phase = (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign accept   = (state_q == IDLE) && start_i;

    // Bus outputs are pure functions of state and held registers, so they stay
    // stable for as long as a request waits for its grant.
    assign busy_o       = (state_q != IDLE);
    assign dma_active_o = busy_o;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign obi_req_o    = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign obi_we_o     = wr_phase;
    assign obi_addr_o   = rd_phase ? src_q : (wr_phase ? dst_q : '0);
    assign obi_wdata_o  = wr_phase ? data_q : '0;
    assign obi_be_o     = busy_o ? '1 : '0;
    assign dma_select_o = obi_addr_o[SelLsb +: SelWidth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        err_q <= 1'b0;
                        if (len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (obi_gnt_i) state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (obi_rvalid_i) begin
                        if (obi_err_i) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (obi_gnt_i) state_q <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (obi_rvalid_i) begin
                        if (obi_err_i) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else if (cnt_q == LenWidth'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= RD_REQ;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; every use is qualified by state.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            src_q <= src_addr_i & AlignMask;
            dst_q <= dst_addr_i & AlignMask;
            cnt_q <= len_i;
        end else if ((state_q == WR_WAIT) && obi_rvalid_i) begin
            src_q <= src_q + WordInc;
            dst_q <= dst_q + WordInc;
            cnt_q <= cnt_q - LenWidth'(1);
        end
        if ((state_q == RD_WAIT) && obi_rvalid_i && !obi_err_i) begin
            data_q <= obi_rdata_i;
        end
    end

endmodule

// File: tb/tb_obi_dma_copy_engine.sv
// Bench for obi_dma_copy_engine: an OBI subordinate with random stalls and latency,
// checked against a word-copy reference list built from the source/length rules.
module tb_obi_dma_copy_engine;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] src_addr_i;
    logic [31:0] dst_addr_i;
    logic [15:0] len_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        dma_active_o;
    logic [1:0]  dma_select_o;
    logic        obi_req_o;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_gnt_i;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } txn_t;

    always #5 clk = ~clk;

    obi_dma_copy_engine #(
        .AddrWidth(32), .DataWidth(32), .LenWidth(16), .NumSbrPorts(4), .SelLsb(12)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .dma_active_o(dma_active_o), .dma_select_o(dma_select_o),
        .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
        .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i),
        .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i)
    );

    // Source memory contents as a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_5EED;
    endfunction

    task automatic check_all_zero(input string name);
        tests++;
        if ({busy_o, done_o, err_o, dma_active_o, obi_req_o, obi_we_o} !== 6'b0 ||
            obi_addr_o !== 32'h0 || obi_wdata_o !== 32'h0 ||
            dma_select_o !== 2'b0 || obi_be_o !== 4'h0) begin
            fails++;
            $display("FAIL %s: busy=%b done=%b err=%b act=%b req=%b we=%b addr=%h wdata=%h sel=%b be=%h, required all 0",
                     name, busy_o, done_o, err_o, dma_active_o, obi_req_o, obi_we_o,
                     obi_addr_o, obi_wdata_o, dma_select_o, obi_be_o);
        end
    endtask

    // One copy, cycle by cycle. err_txn indexes the transaction (reads and writes
    // in issue order) whose response carries an error; -1 for none.
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] len, input int first_stall,
                            input int max_stall, input int max_lat, input int err_txn,
                            input int tail, input bit rst_mid);
        txn_t        exp_q[$];
        txn_t        t;
        logic [31:0] s_al = src & 32'hFFFF_FFFC;
        logic [31:0] d_al = dst & 32'hFFFF_FFFC;
        logic [31:0] wd;
        logic [31:0] pend_addr = 32'h0;
        logic [31:0] h_addr = 32'h0;
        logic [31:0] h_wdata = 32'h0;
        logic        h_we = 1'b0;
        logic [1:0]  h_sel = 2'b0;
        bit          exp_err = 0, exp_busy, pending = 0, in_stall = 0, pend_we = 0;
        bit          aborted = 0, err_at_done = 0;
        int          k = 0, done_cyc = -1, done_cnt = 0, exp_done = 1, txn_cnt = 0;
        int          lat_left = 0, stall_left = 0, cur_stall = 0, cur_lat = 0, pend_idx = 0;

        for (int i = 0; i < int'(len); i++) begin
            t.addr = s_al + 32'(4 * i); t.we = 1'b0; t.data = 32'h0;
            exp_q.push_back(t);
            if (k == err_txn) begin exp_err = 1; break; end
            k++;
            t.addr = d_al + 32'(4 * i); t.we = 1'b1; t.data = mem_word(s_al + 32'(4 * i));
            exp_q.push_back(t);
            if (k == err_txn) begin exp_err = 1; break; end
            k++;
        end

        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                if (done_o === 1'b1) begin
                    done_cnt++;
                    if (done_cyc < 0) begin done_cyc = c; err_at_done = err_o; end
                end
                exp_busy = (len != 16'd0) && (done_cyc < 0);
                tests++;
                if (busy_o !== exp_busy) begin
                    fails++;
                    $display("FAIL busy c%0d: got %b want %b", c, busy_o, exp_busy);
                end
                tests++;
                if (dma_active_o !== busy_o) begin
                    fails++;
                    $display("FAIL dma_active c%0d: got %b want %b", c, dma_active_o, busy_o);
                end
                tests++;
                if (dma_select_o !== obi_addr_o[13:12]) begin
                    fails++;
                    $display("FAIL dma_select c%0d: got %b want %b", c, dma_select_o, obi_addr_o[13:12]);
                end
                if (c == 1) begin
                    tests++;
                    if (err_o !== 1'b0) begin
                        fails++;
                        $display("FAIL err_cleared_on_start: got %b want 0", err_o);
                    end
                end
            end
            if (done_cyc >= 0 && c >= done_cyc + tail) break;

            if (c == 0) begin
                start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = len;
            end else if (busy_o === 1'b1 && $urandom_range(0, 3) == 0) begin
                start_i = 1'b1; src_addr_i = $urandom; dst_addr_i = $urandom; len_i = 16'($urandom);
            end else begin
                start_i = 1'b0;
            end
            obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_rdata_i = $urandom;

            if (pending) begin
                tests++;
                if (obi_req_o !== 1'b0) begin
                    fails++;
                    $display("FAIL single_outstanding c%0d: req=%b want 0", c, obi_req_o);
                end
                if (rst_mid && pend_we) begin
                    rst_ni = 1'b0;
                    #1;
                    check_all_zero("reset_mid_transfer");
                    obi_rvalid_i = 1'b1;
                    @(posedge clk); #1;
                    obi_rvalid_i = 1'b0;
                    @(posedge clk); #1;
                    rst_ni = 1'b1;
                    @(posedge clk); #1;
                    check_all_zero("after_reset_release");
                    aborted = 1;
                    break;
                end
                if (lat_left == 0) begin
                    obi_rvalid_i = 1'b1;
                    obi_err_i = (pend_idx == err_txn);
                    if (!pend_we) obi_rdata_i = mem_word(pend_addr);
                    pending = 0;
                end else begin
                    lat_left--;
                end
            end else if (obi_req_o === 1'b1) begin
                if (!in_stall) begin
                    in_stall = 1;
                    cur_stall = (txn_cnt == 0 && first_stall > 0) ? first_stall
                                                                  : int'($urandom_range(0, max_stall));
                    stall_left = cur_stall;
                    cur_lat = $urandom_range(0, max_lat);
                    h_addr = obi_addr_o; h_we = obi_we_o; h_wdata = obi_wdata_o; h_sel = dma_select_o;
                end else begin
                    tests++;
                    if ({obi_addr_o, obi_we_o, obi_wdata_o, dma_select_o} !== {h_addr, h_we, h_wdata, h_sel}) begin
                        fails++;
                        $display("FAIL stall_stable c%0d: addr=%h we=%b wdata=%h sel=%b want %h %b %h %b",
                                 c, obi_addr_o, obi_we_o, obi_wdata_o, dma_select_o, h_addr, h_we, h_wdata, h_sel);
                    end
                end
                tests++;
                if (obi_be_o !== 4'hF) begin
                    fails++;
                    $display("FAIL be c%0d: got %h want f", c, obi_be_o);
                end
                if (stall_left > 0) begin
                    stall_left--;
                    if ($urandom_range(0, 1) == 1) begin
                        obi_rvalid_i = 1'b1; obi_err_i = 1'($urandom_range(0, 1));
                    end
                end else begin
                    obi_gnt_i = 1'b1;
                    wd = obi_we_o ? obi_wdata_o : 32'h0;
                    tests++;
                    if (txn_cnt >= exp_q.size()) begin
                        fails++;
                        $display("FAIL extra_txn #%0d: addr=%h we=%b, required none", txn_cnt, obi_addr_o, obi_we_o);
                    end else if ({obi_addr_o, obi_we_o, wd} !== {exp_q[txn_cnt].addr, exp_q[txn_cnt].we, exp_q[txn_cnt].data}) begin
                        fails++;
                        $display("FAIL txn #%0d: addr=%h we=%b data=%h want addr=%h we=%b data=%h", txn_cnt,
                                 obi_addr_o, obi_we_o, wd, exp_q[txn_cnt].addr, exp_q[txn_cnt].we, exp_q[txn_cnt].data);
                    end
                    pending = 1; pend_we = obi_we_o; pend_addr = obi_addr_o; pend_idx = txn_cnt;
                    lat_left = cur_lat; in_stall = 0;
                    exp_done += cur_stall + cur_lat + 2;
                    txn_cnt++;
                end
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0;

        if (!aborted) begin
            tests++;
            if (done_cyc < 0) begin
                fails++;
                $display("FAIL timeout: no done_o within budget, required a done pulse");
            end
            tests++;
            if (txn_cnt != exp_q.size()) begin
                fails++;
                $display("FAIL txn_count: got %0d want %0d", txn_cnt, exp_q.size());
            end
            tests++;
            if (done_cnt != 1) begin
                fails++;
                $display("FAIL done_pulses: got %0d want 1", done_cnt);
            end
            tests++;
            if (done_cyc != exp_done) begin
                fails++;
                $display("FAIL done_cycle: got %0d want %0d", done_cyc, exp_done);
            end
            tests++;
            if (err_at_done !== exp_err) begin
                fails++;
                $display("FAIL err_at_done: got %b want %b", err_at_done, exp_err);
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst_ni = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_basic_copy();
        run_copy(32'h1000, 32'h2000, 16'd3, 0, 0, 0, -1, 2, 0);
    endtask

    task automatic test_grant_stall();
        run_copy(32'h1000, 32'h3000, 16'd3, 5, 0, 0, -1, 2, 0);
    endtask

    task automatic test_len_zero();
        run_copy(32'h4000, 32'h5000, 16'd0, 0, 0, 0, -1, 2, 0);
    endtask

    task automatic test_read_error();
        run_copy(32'h1100, 32'h2200, 16'd4, 0, 1, 1, 2, 2, 0);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (err_o !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: got %b want 1", err_o);
        end
        run_copy(32'h1200, 32'h2300, 16'd1, 0, 0, 0, -1, 2, 0);
    endtask

    task automatic test_wrap();
        run_copy(32'hFFFF_FFFC, 32'h0000_2FFC, 16'd2, 0, 2, 1, -1, 2, 0);
    endtask

    task automatic test_reset_mid();
        run_copy(32'h6000, 32'h7000, 16'd3, 0, 0, 0, -1, 2, 1);
        run_copy(32'h6000, 32'h7000, 16'd3, 0, 0, 0, -1, 2, 0);
    endtask

    task automatic test_back_to_back();
        run_copy(32'h8000, 32'h9000, 16'd2, 0, 0, 0, -1, 0, 0);
        run_copy(32'hA000, 32'hB000, 16'd2, 0, 0, 0, -1, 0, 0);
        run_copy(32'hC000, 32'hD000, 16'd0, 0, 0, 0, -1, 2, 0);
    endtask

    task automatic test_random();
        logic [15:0] len;
        int          et;
        for (int n = 0; n < 12; n++) begin
            len = 16'($urandom_range(1, 6));
            et = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * int'(len) - 1)) : -1;
            run_copy($urandom, $urandom, len, 0, 3, 3, et, 2, 0);
        end
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; src_addr_i = 32'h0; dst_addr_i = 32'h0; len_i = 16'h0;
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0; obi_err_i = 1'b0;
        test_reset();
        test_basic_copy();
        test_grant_stall();
        test_len_zero();
        test_read_error();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/obi_dma_copy_engine.md
# obi_dma_copy_engine

Single-channel word-copy DMA engine and the OBI manager feeding the DMA port of the peripheral demux. It reads `len` words starting at a source address and writes them to a destination address, one OBI transaction in flight at a time. It drives the demux's `dma_active`/`dma_select` sideband from the address currently being accessed. A manager stalled by the demux is held at its request, with OBI-stable address and data, until granted.

## Interface
- `AddrWidth`, 32, OBI address width
- `DataWidth`, 32, OBI data width; word size = DataWidth/8 bytes
- `LenWidth`, 16, width of transfer length in words
- `NumSbrPorts`, 4, demux subordinate port count; `SelWidth` = max(1, clog2(NumSbrPorts))
- `SelLsb`, 12, LSB of the address field used as port select
- `clk_i` in 1 clock
- `rst_ni` in 1 asynchronous, active-low reset
- `start_i` in 1 start pulse; sampled only in IDLE
- `src_addr_i` in AddrWidth source byte address; low log2(DataWidth/8) bits ignored
- `dst_addr_i` in AddrWidth destination byte address; low bits ignored
- `len_i` in LenWidth number of words to copy
- `busy_o` out 1 engine not in IDLE
- `done_o` out 1 one-cycle completion pulse, also on abort
- `err_o` out 1 sticky error flag; cleared by the next accepted start
- `dma_active_o` out 1 to demux; equals `busy_o`
- `dma_select_o` out SelWidth to demux; `obi_addr_o[SelLsb +: SelWidth]`
- `obi_req_o` out 1 OBI request
- `obi_addr_o` out AddrWidth word-aligned address
- `obi_we_o` out 1 write enable
- `obi_be_o` out DataWidth/8 byte enable; all ones during writes, all ones during reads
- `obi_wdata_o` out DataWidth write data
- `obi_gnt_i` in 1 OBI grant
- `obi_rvalid_i` in 1 OBI response valid
- `obi_rdata_i` in DataWidth read data
- `obi_err_i` in 1 response error, qualified by `obi_rvalid_i`

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- **IDLE.** On `start_i`, latch src, dst and len; clear `err_o`.
  - len = 0: stay in IDLE and pulse `done_o` in the next cycle.
  - len ≠ 0: go to RD_REQ.
- **RD_REQ.** `obi_req_o`=1, `obi_we_o`=0, `obi_addr_o`=src pointer. Go to RD_WAIT on `obi_gnt_i`.
- **RD_WAIT.** Request low. On `obi_rvalid_i`:
  - no error: latch `obi_rdata_i` into the data register, go to WR_REQ.
  - error: set `err_o`, pulse `done_o`, go to IDLE.
- **WR_REQ.** `obi_req_o`=1, `obi_we_o`=1, address = dst pointer, wdata = data register. Go to WR_WAIT on `obi_gnt_i`.
- **WR_WAIT.** On `obi_rvalid_i`, decrement the remaining count and add DataWidth/8 to both pointers. Then:
  - error: set `err_o`, pulse `done_o`, go to IDLE.
  - count becomes 0: pulse `done_o`, go to IDLE.
  - otherwise: go to RD_REQ.
- Pointer arithmetic is modulo 2^AddrWidth; wrap-around is silent.
- Address, we, wdata and select stay constant while `obi_req_o`=1 and `obi_gnt_i`=0.
- `start_i` in any state other than IDLE is ignored.
- `dma_select_o` reflects the pointer currently driven and stays stable through the WAIT states.

## Timing
- Reset: `busy_o`, `done_o`, `err_o`, `dma_active_o`, `obi_req_o`, `obi_we_o` = 0; `obi_addr_o`, `obi_wdata_o`, `dma_select_o`, `obi_be_o` = 0; state = IDLE.
- Reset asserted mid-transfer aborts immediately, with no done pulse; an outstanding response is dropped.
- `start_i` in cycle 0 puts `obi_req_o` high in cycle 1.
- Best case is 4 cycles per word: gnt in the request cycle, rvalid one cycle later.
- `done_o` is high in the cycle after the final write's `obi_rvalid_i`; `busy_o` is low in that same cycle.
- Exactly one transaction is outstanding; no new request is issued in the cycle a response arrives.
- `obi_rvalid_i` in the REQ states is ignored.

## Test plan
- Copy len=3, src=0x1000, dst=0x2000, zero-wait subordinate → reads 0x1000/1004/1008 and writes 0x2000/2004/2008 with matching data; `done_o` one pulse at cycle 13; `err_o`=0.
- Demux stalls `obi_gnt_i` for 5 cycles on the first read → address, we and select held constant for all 5 cycles; the copy completes correctly.
- len=0 start → no `obi_req_o`; `done_o` pulse in cycle 1; `busy_o` stays 0.
- `obi_err_i`=1 on the second read response of a len=4 copy → one write issued, `err_o`=1, `done_o` pulses; the next start clears `err_o`.
- src=0xFFFF_FFFC, len=2 → second read at 0x0000_0000; `dma_select_o` follows `obi_addr_o[13:12]` for every request.
- `rst_ni` low during WR_WAIT → all outputs 0 immediately; a new start after release runs a clean copy.
